// File: rtl/lcd_hd44780_driver.sv
// HD44780 16x2 character LCD driver, 8-bit write-only bus.
// Runs the power-up init once, then refreshes both lines from a per-frame snapshot forever.
module lcd_hd44780_driver #(
  parameter int PWRUP_CYC = 1_000_000,
  parameter int EN_CYC    = 25,
  parameter int SETUP_CYC = 2,
  parameter int WAIT_CYC  = 2_500,
  parameter int CLR_CYC   = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] L1,
  input  logic [127:0] L2,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic         lcd_on,
  output logic         init_done,
  output logic         frame_done
);

  localparam int MAX_CYC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_L1_ADDR, ST_L1_CHR, ST_L2_ADDR, ST_L2_CHR
  } state_t;

  // PH_WAIT covers the power-up delay and the one-cycle snapshot slot before 0x80.
  typedef enum logic [1:0] {PH_WAIT, PH_SETUP, PH_EN, PH_GAP} phase_t;

  state_t         state_q, state_d, nxt_state;
  phase_t         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     idx_q, idx_d, nxt_idx;
  logic [7:0]     data_q, data_d, sel_data;
  logic           rs_q, rs_d, sel_rs;
  logic           en_q, en_d;
  logic           on_q;
  logic           init_q, init_d;
  logic           frame_q, frame_d;
  logic [127:0]   l1_q, l1_d, l2_q, l2_d;
  logic           start;
  logic           is_clr;
  logic [7:0]     l1_chr [16];
  logic [7:0]     l2_chr [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_chr
      assign l1_chr[gi] = l1_q[127-8*gi -: 8];
      assign l2_chr[gi] = l2_q[127-8*gi -: 8];
    end
  endgenerate

  assign is_clr = !rs_q && (data_q == 8'h01);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rs_d      = rs_q;
    init_d    = init_q;
    frame_d   = 1'b0;
    l1_d      = l1_q;
    l2_d      = l2_q;
    start     = 1'b0;
    nxt_state = state_q;
    nxt_idx   = idx_q;
    sel_data  = 8'h00;
    sel_rs    = 1'b0;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (phase_q)
        PH_WAIT: begin
          start   = 1'b1;
          nxt_idx = '0;
          if (state_q == ST_PWRUP) begin
            nxt_state = ST_INIT;
          end else begin
            l1_d      = L1;
            l2_d      = L2;
            nxt_state = ST_L1_ADDR;
          end
        end
        PH_SETUP: begin
          phase_d = PH_EN;
          cnt_d   = CW'(EN_CYC - 1);
        end
        PH_EN: begin
          phase_d = PH_GAP;
          cnt_d   = is_clr ? CW'(CLR_CYC - 1) : CW'(WAIT_CYC - 1);
        end
        PH_GAP: begin
          start   = 1'b1;
          nxt_idx = '0;
          case (state_q)
            ST_INIT: begin
              if (idx_q != 5'd3) begin
                nxt_idx = idx_q + 5'd1;
              end else begin
                start   = 1'b0;
                init_d  = 1'b1;
                state_d = ST_L1_ADDR;
                phase_d = PH_WAIT;
              end
            end
            ST_L1_ADDR: nxt_state = ST_L1_CHR;
            ST_L1_CHR: begin
              if (idx_q != 5'd15) nxt_idx = idx_q + 5'd1;
              else                nxt_state = ST_L2_ADDR;
            end
            ST_L2_ADDR: nxt_state = ST_L2_CHR;
            ST_L2_CHR: begin
              if (idx_q != 5'd15) begin
                nxt_idx = idx_q + 5'd1;
              end else begin
                start   = 1'b0;
                frame_d = 1'b1;
                state_d = ST_L1_ADDR;
                phase_d = PH_WAIT;
              end
            end
            default: start = 1'b0;
          endcase
        end
      endcase
    end

    case (nxt_state)
      ST_INIT: begin
        case (nxt_idx[1:0])
          2'd0:    sel_data = 8'h38;
          2'd1:    sel_data = 8'h0C;
          2'd2:    sel_data = 8'h01;
          default: sel_data = 8'h06;
        endcase
      end
      ST_L1_ADDR: sel_data = 8'h80;
      ST_L1_CHR: begin
        sel_data = l1_chr[nxt_idx[3:0]];
        sel_rs   = 1'b1;
      end
      ST_L2_ADDR: sel_data = 8'hC0;
      ST_L2_CHR: begin
        sel_data = l2_chr[nxt_idx[3:0]];
        sel_rs   = 1'b1;
      end
      default: sel_data = 8'h00;
    endcase

    if (start) begin
      state_d = nxt_state;
      idx_d   = nxt_idx;
      phase_d = PH_SETUP;
      cnt_d   = CW'(SETUP_CYC - 1);
      data_d  = sel_data;
      rs_d    = sel_rs;
    end

    en_d = (phase_d == PH_EN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRUP;
      phase_q <= PH_WAIT;
      cnt_q   <= CW'(PWRUP_CYC - 1);
      idx_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      init_q  <= 1'b0;
      frame_q <= 1'b0;
      l1_q    <= '0;
      l2_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      on_q    <= 1'b1;
      init_q  <= init_d;
      frame_q <= frame_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
    end
  end

  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign lcd_on     = on_q;
  assign init_done  = init_q;
  assign frame_done = frame_q;

endmodule
